// File: rtl/fwd_operand_stage_pkg.sv
// Shared widths and select-code encoding for the ID/EX operand forwarding stage.
package fwd_operand_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF     = 5;

  // Select code 0 means register file; stage i is reported as i+1.
  localparam int SEL_RF = 0;

  function automatic int sel_stg(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/fwd_operand_stage_match_sel.sv
// Combinational youngest-producer matcher and data mux for one source operand.
module fwd_match_sel
  import fwd_operand_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AW       = AW_DEF,
  parameter int NUM_STG  = 3,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = $clog2(NUM_STG + 1)
) (
  input  logic [AW-1:0]             i_rs,
  input  logic [DATA_W-1:0]         i_rf_dat,
  input  logic [NUM_STG-1:0]        i_stg_valid,
  input  logic [NUM_STG-1:0]        i_stg_wr_en,
  input  logic [NUM_STG-1:0]        i_stg_ready,
  input  logic [NUM_STG*AW-1:0]     i_stg_rd,
  input  logic [NUM_STG*DATA_W-1:0] i_stg_data,
  output logic [DATA_W-1:0]         o_op,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_hazard
);

  logic w_blocked;

  assign w_blocked = (ZERO_REG != 0) && (i_rs == '0);

  // Walk from oldest to youngest so the lowest matching index is the last to assign.
  always_comb begin
    o_op     = i_rf_dat;
    o_sel    = SEL_W'(SEL_RF);
    o_hazard = 1'b0;
    for (int i = NUM_STG - 1; i >= 0; i--) begin
      if (!w_blocked && i_stg_valid[i] && i_stg_wr_en[i] &&
          (i_stg_rd[i*AW +: AW] == i_rs)) begin
        if (i_stg_ready[i]) begin
          o_op     = i_stg_data[i*DATA_W +: DATA_W];
          o_sel    = SEL_W'(sel_stg(i));
          o_hazard = 1'b0;
        end else begin
          o_op     = i_rf_dat;
          o_sel    = SEL_W'(SEL_RF);
          o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand forwarding stage: per-operand forwarding, load-use bubble, registered EX operands.
module fwd_operand_stage
  import fwd_operand_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AW       = AW_DEF,
  parameter int NUM_STG  = 3,
  parameter int ZERO_REG = 1,
  localparam int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [AW-1:0]             in_rs1,
  input  logic [AW-1:0]             in_rs2,
  input  logic [DATA_W-1:0]         in_rf_a,
  input  logic [DATA_W-1:0]         in_rf_b,
  input  logic [NUM_STG-1:0]        stg_valid,
  input  logic [NUM_STG-1:0]        stg_wr_en,
  input  logic [NUM_STG*AW-1:0]     stg_rd,
  input  logic [NUM_STG*DATA_W-1:0] stg_data,
  input  logic [NUM_STG-1:0]        stg_ready,
  input  logic                      stall_in,
  input  logic                      flush,
  output logic                      in_ready,
  output logic                      hazard,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_op_a,
  output logic [DATA_W-1:0]         out_op_b,
  output logic [SEL_W-1:0]          out_sel_a,
  output logic [SEL_W-1:0]          out_sel_b
);

  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic [SEL_W-1:0]  w_sel_a, w_sel_b;
  logic              w_haz_a, w_haz_b, w_hazard;

  logic              r_valid;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic [SEL_W-1:0]  r_sel_a, r_sel_b;

  fwd_match_sel #(
    .DATA_W(DATA_W), .AW(AW), .NUM_STG(NUM_STG), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
  ) u_match_a (
    .i_rs(in_rs1), .i_rf_dat(in_rf_a),
    .i_stg_valid(stg_valid), .i_stg_wr_en(stg_wr_en), .i_stg_ready(stg_ready),
    .i_stg_rd(stg_rd), .i_stg_data(stg_data),
    .o_op(w_op_a), .o_sel(w_sel_a), .o_hazard(w_haz_a)
  );

  fwd_match_sel #(
    .DATA_W(DATA_W), .AW(AW), .NUM_STG(NUM_STG), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
  ) u_match_b (
    .i_rs(in_rs2), .i_rf_dat(in_rf_b),
    .i_stg_valid(stg_valid), .i_stg_wr_en(stg_wr_en), .i_stg_ready(stg_ready),
    .i_stg_rd(stg_rd), .i_stg_data(stg_data),
    .o_op(w_op_b), .o_sel(w_sel_b), .o_hazard(w_haz_b)
  );

  assign w_hazard = in_valid & (w_haz_a | w_haz_b);
  assign hazard   = w_hazard;
  assign in_ready = ~stall_in & ~w_hazard;

  // Flush beats stall, and stall beats the hazard bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else begin
      r_valid <= in_valid;
      r_op_a  <= w_op_a;
      r_op_b  <= w_op_b;
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  assign out_valid = r_valid;
  assign out_op_a  = r_op_a;
  assign out_op_b  = r_op_b;
  assign out_sel_a = r_sel_a;
  assign out_sel_b = r_sel_b;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a reference model.
module tb_fwd_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rs1, in_rs2;
  logic [31:0] in_rf_a, in_rf_b;
  logic [2:0]  stg_valid, stg_wr_en, stg_ready;
  logic [14:0] stg_rd;
  logic [95:0] stg_data;
  logic        stall_in, flush;
  logic        in_ready, hazard, out_valid;
  logic [31:0] out_op_a, out_op_b;
  logic [1:0]  out_sel_a, out_sel_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the EX-side register contents.
  logic        e_valid;
  logic [31:0] e_a, e_b;
  logic [1:0]  e_sa, e_sb;

  always #5 clk = ~clk;

  fwd_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rf_a(in_rf_a), .in_rf_b(in_rf_b), .stg_valid(stg_valid), .stg_wr_en(stg_wr_en),
    .stg_rd(stg_rd), .stg_data(stg_data), .stg_ready(stg_ready), .stall_in(stall_in),
    .flush(flush), .in_ready(in_ready), .hazard(hazard), .out_valid(out_valid),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_sel_a(out_sel_a), .out_sel_b(out_sel_b)
  );

  // First (youngest) producer writing rs decides; r0 never forwards.
  task automatic ref_operand(input logic [4:0] rs, input logic [31:0] rf,
                             output logic [31:0] op, output logic [1:0] sel, output logic hz);
    bit done = 0;
    op = rf; sel = 2'd0; hz = 1'b0;
    if (rs != 5'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (!done && stg_valid[i] && stg_wr_en[i] && stg_rd[i*5 +: 5] == rs) begin
          done = 1;
          if (stg_ready[i]) begin
            op  = stg_data[i*32 +: 32];
            sel = 2'(i + 1);
          end else begin
            hz = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic ref_comb(output logic [31:0] oa, output logic [31:0] ob,
                          output logic [1:0] sa, output logic [1:0] sb,
                          output logic hz, output logic rdy);
    logic ha, hb;
    ref_operand(in_rs1, in_rf_a, oa, sa, ha);
    ref_operand(in_rs2, in_rf_b, ob, sb, hb);
    hz  = in_valid & (ha | hb);
    rdy = !stall_in && !hz;
  endtask

  task automatic tick();
    logic [31:0] oa, ob;
    logic [1:0]  sa, sb;
    logic        hz, rdy;
    ref_comb(oa, ob, sa, sb, hz, rdy);
    if (rst || flush || (!stall_in && hz)) begin
      e_valid = 0; e_a = 0; e_b = 0; e_sa = 0; e_sb = 0;
    end else if (!stall_in) begin
      e_valid = in_valid; e_a = oa; e_b = ob; e_sa = sa; e_sb = sb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rf_a = 0; in_rf_b = 0;
    stg_valid = 0; stg_wr_en = 0; stg_ready = 0; stg_rd = 0; stg_data = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic set_stg(input int i, input logic v, input logic w, input logic [4:0] rd,
                         input logic [31:0] d, input logic r);
    stg_valid[i] = v; stg_wr_en[i] = w; stg_ready[i] = r;
    stg_rd[i*5 +: 5] = rd; stg_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; in_valid = 1; in_rf_a = 32'h55; in_rf_b = 32'h66;
    tick(); tick();
    n_tests++;
    if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%0b a=%h b=%h sa=%0d sb=%0d want all 0",
               out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b);
    end
    rst = 0; in_valid = 0;
    n_tests++;
    if (hazard !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle_comb got hazard=%0b in_ready=%0b want 0/1", hazard, in_ready);
    end
  endtask

  task automatic test_no_fwd();
    clear_inputs();
    in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_rf_a = 32'h11; in_rf_b = 32'h22;
    tick();
    n_tests++;
    if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== {1'b1, 32'h11, 32'h22, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL no_fwd got v=%0b a=%h b=%h sa=%0d sb=%0d want 1 11 22 0 0",
               out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    in_valid = 1; in_rs1 = 5; in_rs2 = 9; in_rf_a = 32'h1; in_rf_b = 32'h2;
    set_stg(0, 1, 1, 5, 32'hAAAA, 1);
    set_stg(2, 1, 1, 5, 32'hCCCC, 1);
    tick();
    n_tests++;
    if (out_op_a !== 32'hAAAA || out_sel_a !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL priority_youngest got a=%h sa=%0d v=%0b want AAAA 1 1", out_op_a, out_sel_a, out_valid);
    end
    stg_valid[0] = 0;
    tick();
    n_tests++;
    if (out_op_a !== 32'hCCCC || out_sel_a !== 2'd3) begin
      n_fail++;
      $display("FAIL priority_oldest got a=%h sa=%0d want CCCC 3", out_op_a, out_sel_a);
    end
    // Younger non-writing producer must not shadow an older writer.
    set_stg(0, 1, 0, 5, 32'hBBBB, 1);
    tick();
    n_tests++;
    if (out_op_a !== 32'hCCCC || out_sel_a !== 2'd3) begin
      n_fail++;
      $display("FAIL wr_en_gate got a=%h sa=%0d want CCCC 3", out_op_a, out_sel_a);
    end
    // Both operands may pick the same stage.
    in_rs2 = 5;
    tick();
    n_tests++;
    if (out_op_b !== 32'hCCCC || out_sel_b !== 2'd3 || out_op_a !== 32'hCCCC) begin
      n_fail++;
      $display("FAIL shared_stage got a=%h b=%h sb=%0d want CCCC CCCC 3", out_op_a, out_op_b, out_sel_b);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    in_valid = 1; in_rs1 = 0; in_rf_a = 32'h77; in_rs2 = 6; in_rf_b = 32'h88;
    set_stg(1, 1, 1, 0, 32'hDEAD, 1);
    tick();
    n_tests++;
    if (out_op_a !== 32'h77 || out_sel_a !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_reg got a=%h sa=%0d want 77 0", out_op_a, out_sel_a);
    end
    stg_ready[1] = 0;
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg_hazard got hazard=%0b want 0", hazard);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    in_valid = 1; in_rs1 = 2; in_rs2 = 7; in_rf_a = 32'h10; in_rf_b = 32'h20;
    set_stg(0, 1, 1, 7, 32'h9999, 0);
    #1;
    n_tests++;
    if (hazard !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_comb got hazard=%0b in_ready=%0b want 1/0", hazard, in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_op_b !== 32'd0) begin
      n_fail++;
      $display("FAIL load_use_bubble got v=%0b b=%h want 0 0", out_valid, out_op_b);
    end
    set_stg(0, 0, 0, 0, 32'h0, 0);
    set_stg(1, 1, 1, 7, 32'h1234, 1);
    tick();
    n_tests++;
    if ({out_valid, out_op_b, out_sel_b} !== {1'b1, 32'h1234, 2'd2}) begin
      n_fail++;
      $display("FAIL load_use_resume got v=%0b b=%h sb=%0d want 1 1234 2", out_valid, out_op_b, out_sel_b);
    end
    in_valid = 0;
    set_stg(1, 1, 1, 7, 32'h1234, 0);
    #1;
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_needs_valid got hazard=%0b want 0", hazard);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    in_valid = 1; in_rs1 = 8; in_rs2 = 9; in_rf_a = 32'hA1; in_rf_b = 32'hB2;
    tick();
    stall_in = 1;
    for (int k = 0; k < 3; k++) begin
      in_rf_a = $urandom; in_rf_b = $urandom; in_valid = k[0];
      set_stg(0, 1, 1, 8, $urandom, k[0]);
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready cycle %0d got in_ready=%0b want 0", k, in_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== {1'b1, 32'hA1, 32'hB2, 2'd0, 2'd0}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got v=%0b a=%h b=%h want 1 A1 B2", k, out_valid, out_op_a, out_op_b);
      end
    end
    flush = 1;
    tick();
    n_tests++;
    if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== 69'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall got v=%0b a=%h b=%h want 0 0 0", out_valid, out_op_a, out_op_b);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    in_valid = 1; in_rs1 = 4; in_rf_a = 32'h44; in_rf_b = 32'h45;
    tick();
    set_stg(0, 1, 1, 4, 32'h0, 0);
    tick();
    rst = 1;
    tick();
    n_tests++;
    if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_mid got v=%0b a=%h b=%h want 0", out_valid, out_op_a, out_op_b);
    end
    rst = 0;
    set_stg(0, 1, 1, 4, 32'h4321, 1);
    tick();
    n_tests++;
    if ({out_valid, out_op_a, out_sel_a} !== {1'b1, 32'h4321, 2'd1}) begin
      n_fail++;
      $display("FAIL reset_resume got v=%0b a=%h sa=%0d want 1 4321 1", out_valid, out_op_a, out_sel_a);
    end
  endtask

  task automatic test_random();
    logic [31:0] oa, ob;
    logic [1:0]  sa, sb;
    logic        hz, rdy;
    clear_inputs();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(31) == 0);
      flush    = ($urandom_range(15) == 0);
      stall_in = ($urandom_range(7) == 0);
      in_valid = ($urandom_range(3) != 0);
      in_rs1   = 5'($urandom_range(7));
      in_rs2   = 5'($urandom_range(7));
      in_rf_a  = $urandom;
      in_rf_b  = $urandom;
      for (int i = 0; i < 3; i++)
        set_stg(i, $urandom_range(1), $urandom_range(3) != 0, 5'($urandom_range(7)),
                $urandom, $urandom_range(3) != 0);
      #1;
      ref_comb(oa, ob, sa, sb, hz, rdy);
      n_tests++;
      if (hazard !== hz || in_ready !== rdy) begin
        n_fail++;
        $display("FAIL rand_comb iter %0d got hazard=%0b in_ready=%0b want %0b/%0b", n, hazard, in_ready, hz, rdy);
      end
      tick();
      n_tests++;
      if ({out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b} !== {e_valid, e_a, e_b, e_sa, e_sb}) begin
        n_fail++;
        $display("FAIL rand_regs iter %0d got v=%0b a=%h b=%h sa=%0d sb=%0d want v=%0b a=%h b=%h sa=%0d sb=%0d",
                 n, out_valid, out_op_a, out_op_b, out_sel_a, out_sel_b, e_valid, e_a, e_b, e_sa, e_sb);
      end
    end
  endtask

  initial begin
    e_valid = 0; e_a = 0; e_b = 0; e_sa = 0; e_sb = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_no_fwd();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
